bus_mux_reg: RTL

- Parametrised, registered successor to the 32-source one-hot datapath bus: NSRC sources of WIDTH bits, each gated by its own "out" strobe.
- Adds a one-cycle output register and a stall enable. Also adds one-hot violation detection, a saturating error counter and an encoded source index.
- Sits between the register file / special registers (HI, LO, Z, PC, MDR, InPort, C) and every bus consumer in the CPU datapath.

---
 rtl/bus_mux_reg.sv | 118 +++++++++++
 1 files changed

// File: rtl/bus_mux_reg.sv
// Registered NSRC-to-1 one-hot bus multiplexer with stall, multi-select detection,
// saturating error counter and encoded source index. Optional macro: BUS_MUX_PRIORITY_EN.
module bus_mux_reg #(
  parameter int WIDTH        = 32,
  parameter int NSRC         = 32,
  parameter int IDX_W        = $clog2(NSRC),
  parameter int CNT_W        = 8,
  parameter int HOLD_ON_IDLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NSRC-1:0]        src_out,
  input  logic [NSRC*WIDTH-1:0]  src_data,
  input  logic                   bus_en,
  input  logic                   err_clr,
  output logic [WIDTH-1:0]       bus_out,
  output logic                   bus_valid,
  output logic [IDX_W-1:0]       bus_src,
  output logic                   sel_err,
  output logic [CNT_W-1:0]       err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] bus_out_q, bus_out_d;
  logic             bus_valid_q, bus_valid_d;
  logic [IDX_W-1:0] bus_src_q, bus_src_d;
  logic             sel_err_q, sel_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             any_s;
  logic             multi_s;
  logic [IDX_W-1:0] low_idx_s;
  logic [WIDTH-1:0] low_data_s;

  // Clearing the lowest set bit leaves something only when two or more strobes are set.
  assign any_s   = |src_out;
  assign multi_s = |(src_out & (src_out - NSRC'(1)));

  // Lowest-indexed set strobe and its data; for a one-hot select this is the only one.
  always_comb begin
    low_idx_s  = '0;
    low_data_s = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      low_idx_s  = src_out[i] ? IDX_W'(i) : low_idx_s;
      low_data_s = src_out[i] ? src_data[i*WIDTH +: WIDTH] : low_data_s;
    end
  end

  // Next-state for the bus register, source index, valid flag and error pulse.
  always_comb begin
    bus_out_d   = bus_out_q;
    bus_valid_d = bus_valid_q;
    bus_src_d   = bus_src_q;
    sel_err_d   = 1'b0;
    if (bus_en) begin
      if (multi_s) begin
        sel_err_d = 1'b1;
`ifdef BUS_MUX_PRIORITY_EN
        bus_out_d   = low_data_s;
        bus_src_d   = low_idx_s;
        bus_valid_d = 1'b1;
`else
        bus_valid_d = 1'b0;
`endif
      end else if (any_s) begin
        bus_out_d   = low_data_s;
        bus_src_d   = low_idx_s;
        bus_valid_d = 1'b1;
      end else begin
        bus_valid_d = 1'b0;
        if (HOLD_ON_IDLE == 0) begin
          bus_out_d = '0;
        end else begin
          bus_out_d = bus_out_q;
        end
      end
    end else begin
      sel_err_d = 1'b0;
    end
  end

  // Error counter: clear dominates, otherwise count multi-selects up to saturation.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (bus_en && multi_s && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      bus_src_q   <= '0;
      sel_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
      bus_src_q   <= bus_src_d;
      sel_err_q   <= sel_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus_out   = bus_out_q;
  assign bus_valid = bus_valid_q;
  assign bus_src   = bus_src_q;
  assign sel_err   = sel_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
